// File: rtl/btn_debounce.sv
// Push-button conditioner: per channel a 2-FF synchroniser, polarity
// normalisation to active-high and a counter-based debouncer. Produces a
// stable registered level plus one-cycle press/release strobes that line up
// with the first cycle of the new level.
module btn_debounce #(
    parameter int unsigned      NBTN        = 7,
    parameter int unsigned      CNT_MAX     = 250000,
    parameter logic [NBTN-1:0]  INVERT_MASK = NBTN'(7'b0000001)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [NBTN-1:0] i_btn,
    output logic [NBTN-1:0] o_btn,
    output logic [NBTN-1:0] o_press,
    output logic [NBTN-1:0] o_release
);

    // Counter only ever needs to reach CNT_MAX-1 before it is cleared.
    localparam int unsigned CNT_W = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic [NBTN-1:0]  sync1_q, sync1_d;
    logic [NBTN-1:0]  sync2_q, sync2_d;
    logic [NBTN-1:0]  s_q, s_d;
    logic [NBTN-1:0]  press_q, press_d;
    logic [NBTN-1:0]  rls_q, rls_d;
    logic [CNT_W-1:0] cnt_q [NBTN];
    logic [CNT_W-1:0] cnt_d [NBTN];
    logic [NBTN-1:0]  norm_c;

    // Synchroniser next state: two plain shift stages.
    always_comb begin
        sync1_d = i_btn;
        sync2_d = sync1_q;
    end

    // Normalised (active-high) view of the synchronised pins.
    always_comb begin
        norm_c = sync2_q ^ INVERT_MASK;
    end

    // Debounce: a change is accepted only after CNT_MAX consecutive
    // disagreeing samples; any agreeing sample restarts the count.
    always_comb begin
        s_d     = s_q;
        press_d = '0;
        rls_d   = '0;
        for (int i = 0; i < int'(NBTN); i++) begin
            cnt_d[i] = '0;
            if (norm_c[i] != s_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    s_d[i]     = norm_c[i];
                    press_d[i] = norm_c[i];
                    rls_d[i]   = ~norm_c[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // State registers; reset parks the synchroniser at the raw idle level
    // so releasing reset does not look like a pin edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync1_q <= INVERT_MASK;
            sync2_q <= INVERT_MASK;
            s_q     <= '0;
            press_q <= '0;
            rls_q   <= '0;
            for (int i = 0; i < int'(NBTN); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            s_q     <= s_d;
            press_q <= press_d;
            rls_q   <= rls_d;
            for (int i = 0; i < int'(NBTN); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Outputs come straight from flops.
    assign o_btn     = s_q;
    assign o_press   = press_q;
    assign o_release = rls_q;

endmodule
